alu_arbiter: RTL
================

# alu_arbiter

Round-robin controller that shares one ALU instance between `NUM_REQ` requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU's `enable`/`A`/`B`/`ALU_function` inputs for exactly one cycle. It then waits for `ALU_result_valid`, with a timeout, and returns the result to the granted requester. Divide-by-zero is trapped before the ALU is ever enabled.

## Interface
- `DATA_WIDTH`, 8, operand width; result is `2*DATA_WIDTH`.
- `NUM_REQ`, 2, number of requesters (2..8).
- `TIMEOUT`, 15, WAIT cycles allowed before an error response (≥2).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; all state cleared immediately on assertion.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_A`  in  NUM_REQ*DATA_WIDTH  operand A; slice i belongs to requester i.
- `req_B`  in  NUM_REQ*DATA_WIDTH  operand B; slice i belongs to requester i.
- `req_func`  in  NUM_REQ*4  ALU function code; slice i belongs to requester i.
- `req_ready`  out  NUM_REQ  one-hot accept.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle response strobe.
- `rsp_result`  out  2*DATA_WIDTH  result, shared by all requesters.
- `rsp_error`  out  1  qualifies `rsp_valid`; set on timeout or divide-by-zero.
- `alu_enable`  out  1  to ALU `enable`.
- `alu_A`  out  DATA_WIDTH  to ALU `A`.
- `alu_B`  out  DATA_WIDTH  to ALU `B`.
- `alu_function`  out  4  to ALU `ALU_function`.
- `alu_result_valid`  in  1  from ALU.
- `alu_result`  in  2*DATA_WIDTH  from ALU.
- `busy`  out  1  high in every state except IDLE.

## Operation
States are IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - `req_ready` is combinational: one-hot grant to the first asserted `req_valid` found searching from `ptr` upward with wrap-around.
  - On handshake, latch the requester's A, B, func and grant index.
  - If func==4'b0011 and B==0, go to RESP with error. Otherwise go to ISSUE.
- **ISSUE**
  - `alu_enable`=1 for exactly this cycle; `alu_A`/`alu_B`/`alu_function` come from the latches.
  - Clear `tcnt`, then go to WAIT.
  - `alu_result_valid` seen in ISSUE is stale and ignored.
- **WAIT**
  - `alu_enable`=0; operand outputs hold their latched values.
  - If `alu_result_valid`=1: capture `alu_result`, clear error, go to RESP.
  - Else if `tcnt`==TIMEOUT-1: result=0, error=1, go to RESP.
  - Else increment `tcnt`.
  - If valid and timeout coincide in the same cycle, valid wins (no error).
- **RESP**
  - `rsp_valid[grant]`=1 for one cycle; `rsp_result`/`rsp_error` are valid only in this cycle.
  - Set `ptr` = grant+1, wrapping at NUM_REQ, then go to IDLE.
- Requesters must hold `req_valid` and operands stable until `req_ready`. `req_valid` outside IDLE is ignored (no ready is given).
- Any func value 0..15 is passed through unchanged. Only DIV is checked.
- Only one operation is in flight at a time; no queuing.

## Timing
- Reset values:
  - state=IDLE, `ptr`=0, `tcnt`=0.
  - All outputs 0, including `req_ready`. `req_ready` may assert combinationally in the first IDLE cycle after reset deasserts.
- Nominal latency, with an ALU that raises valid the cycle after enable:
  - Handshake in cycle N.
  - ISSUE in N+1.
  - WAIT in N+2 (valid sampled).
  - RESP (`rsp_valid`) in N+3.
  - IDLE with a new accept possible in N+4.
  - Throughput: 1 operation per 4 cycles.
- Divide-by-zero: handshake in N, error response in N+1, IDLE in N+2.
- Timeout: `rsp_valid` with error in cycle N+2+TIMEOUT.
- Reset during ISSUE, WAIT or RESP:
  - Abort to IDLE immediately.
  - No `rsp_valid` is ever produced for the aborted operation.
  - `ptr` returns to 0.

## Structure
- Package `alu_ctrl_pkg` holds:
  - The state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3).
  - Function constants: ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5.
- Sub-module `rr_arbiter` (parameter NUM_REQ): inputs `req` vector and `ptr`; outputs one-hot `grant` and binary index. Purely combinational.
- The top level holds the FSM, operand/result latches, `ptr` and `tcnt` (width `$clog2(TIMEOUT)`).

## Test plan
- **Single ADD.** Req0 sends A=8'h54, B=8'h2A, func 0.
  - `alu_enable` high for exactly 1 cycle.
  - `rsp_valid`=2'b01 three cycles after the handshake, `rsp_result`=16'h007E, error=0.
- **Round-robin contention.** Both requesters hold MUL (8'h54×8'h2A) continuously from reset.
  - Grants go 0,1,0,1.
  - Each `rsp_result`=16'h0DC8, on the matching `rsp_valid` bit.
- **Divide-by-zero.** Req1 sends DIV with A=8'h54, B=0.
  - `alu_enable` never asserts.
  - `rsp_valid`=2'b10 with error=1, result 0, one cycle after the handshake.
- **Timeout.** The ALU stub never raises valid.
  - Error response arrives at N+2+TIMEOUT (cycle N+17 for the default).
  - The next request is then serviced normally.
- **Reset mid-operation.** Assert reset during WAIT.
  - All outputs go to 0 immediately.
  - No `rsp_valid` is seen.
  - After release, req1 alone (OR, A=8'hF4, B=8'h2C) returns 16'h00FC.
- **Valid/timeout coincidence.** The stub raises valid in exactly the final WAIT cycle.
  - Response carries the captured result with error=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: FSM state encoding,
// ALU function codes and the divide-by-zero trap predicate.
package alu_ctrl_pkg;

    // FSM state encoding (kept as plain constants for legacy tool flows)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // ALU function codes
    localparam logic [3:0] FUNC_ADD = 4'd0;
    localparam logic [3:0] FUNC_SUB = 4'd1;
    localparam logic [3:0] FUNC_MUL = 4'd2;
    localparam logic [3:0] FUNC_DIV = 4'd3;
    localparam logic [3:0] FUNC_AND = 4'd4;
    localparam logic [3:0] FUNC_OR  = 4'd5;

    // A division with a zero divisor is answered locally and never reaches the ALU.
    function automatic logic is_div_by_zero(input logic [3:0] func, input logic b_is_zero);
        return (func == FUNC_DIV) && b_is_zero;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request found
// searching upward from ptr, wrapping at NUM_REQ.
module rr_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    int   idx;
    logic found;

    // Scan from ptr with wrap-around; the first hit wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path can infer a latch.
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[IW'(idx)]) begin
                found              = 1'b1;
                grant[IW'(idx)]    = 1'b1;
                grant_idx          = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters: accepts one operation at a time,
// pulses the ALU enable for one cycle, waits (with timeout) for the result and
// returns it to the granted requester. Divide-by-zero is trapped locally.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_A,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_B,
    input  logic [NUM_REQ*4-1:0]      req_func,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [2*DATA_WIDTH-1:0]   rsp_result,
    output logic                      rsp_error,
    output logic                      alu_enable,
    output logic [DATA_WIDTH-1:0]     alu_A,
    output logic [DATA_WIDTH-1:0]     alu_B,
    output logic [3:0]                alu_function,
    input  logic                      alu_result_valid,
    input  logic [2*DATA_WIDTH-1:0]   alu_result,
    output logic                      busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT);

    logic [1:0]              state;
    logic [IW-1:0]           ptr;
    logic [TW-1:0]           tcnt;
    logic [IW-1:0]           grant_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [3:0]              func_q;
    logic [2*DATA_WIDTH-1:0] result_q;
    logic                    error_q;

    logic [NUM_REQ-1:0]      arb_grant;
    logic [IW-1:0]           arb_idx;
    logic [DATA_WIDTH-1:0]   sel_a;
    logic [DATA_WIDTH-1:0]   sel_b;
    logic [3:0]              sel_func;
    logic                    accept;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Ready is offered only in IDLE and never while reset is held.
    always_comb begin
        req_ready = (state == ST_IDLE && !reset) ? arb_grant : '0;
        accept    = |req_ready;
    end

    // Pick the granted requester's operands out of the packed buses.
    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_func = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_a    = req_A[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b    = req_B[i*DATA_WIDTH +: DATA_WIDTH];
                sel_func = req_func[i*4 +: 4];
            end
        end
    end

    // Controller FSM with operand/result latches, round-robin pointer and timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            tcnt     <= '0;
            grant_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            func_q   <= '0;
            result_q <= '0;
            error_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        func_q  <= sel_func;
                        grant_q <= arb_idx;
                        if (is_div_by_zero(sel_func, sel_b == '0)) begin
                            result_q <= '0;
                            error_q  <= 1'b1;
                            state    <= ST_RESP;
                        end else begin
                            state    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // A result_valid seen here belongs to nothing we issued.
                    tcnt  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A valid arriving on the final cycle still wins over the timeout.
                    if (alu_result_valid) begin
                        result_q <= alu_result;
                        error_q  <= 1'b0;
                        state    <= ST_RESP;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        result_q <= '0;
                        error_q  <= 1'b1;
                        state    <= ST_RESP;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ST_RESP: begin
                    ptr   <= (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ALU drive and response outputs decoded from the current state.
    always_comb begin
        alu_enable   = (state == ST_ISSUE);
        alu_A        = a_q;
        alu_B        = b_q;
        alu_function = func_q;
        busy         = (state != ST_IDLE);
        rsp_valid    = '0;
        rsp_result   = '0;
        rsp_error    = 1'b0;
        if (state == ST_RESP) begin
            rsp_valid[grant_q] = 1'b1;
            rsp_result         = result_q;
            rsp_error          = error_q;
        end
    end

endmodule
